// File: rtl/case_stream_sequencer_if.sv
// -----------------------------------------------------------------------------
// case_stream_sequencer_if
// Bundles the two AXI-Stream-style output channels of case_stream_sequencer.
//   H channel     : H_row (J x DATA_W), y (2 x DATA_W), H_row_tvalid,
//                   H_row_tlast, H_row_tready
//   alpha channel : alpha_u_col (J x ALPHA_W), alpha_u_col_tvalid,
//                   alpha_u_col_tlast, alpha_u_col_tready
// modport master : the sequencer (drives data/valid/last, samples ready)
// modport slave  : the consumer  (drives ready, samples data/valid/last)
// -----------------------------------------------------------------------------
interface case_stream_sequencer_if #(
    parameter int J       = 4,
    parameter int DATA_W  = 64,
    parameter int ALPHA_W = 8
);
    logic [J*DATA_W-1:0]  H_row;
    logic [2*DATA_W-1:0]  y;
    logic                 H_row_tvalid;
    logic                 H_row_tlast;
    logic                 H_row_tready;
    logic [J*ALPHA_W-1:0] alpha_u_col;
    logic                 alpha_u_col_tvalid;
    logic                 alpha_u_col_tlast;
    logic                 alpha_u_col_tready;

    modport master (
        output H_row, y, H_row_tvalid, H_row_tlast,
        input  H_row_tready,
        output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
        input  alpha_u_col_tready
    );

    modport slave (
        input  H_row, y, H_row_tvalid, H_row_tlast,
        output H_row_tready,
        input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
        output alpha_u_col_tready
    );
endinterface

// File: rtl/case_stream_sequencer.sv
// -----------------------------------------------------------------------------
// case_stream_sequencer
// Holds one detector channel case (I rows of J H entries, I paired y samples,
// A alpha columns of J weights) and streams it on start: all H rows on the H
// channel, then all alpha columns on the alpha channel, with full tready
// backpressure. Storage is loaded through the cfg port while idle and is not
// cleared by reset.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/sel/addr/wdata : load port (sel 0 H row, 1 y, 2 alpha col, 3 none)
//   start             : begin a run (only honoured in IDLE)
//   frames            : frame count, 0 behaves as 1 (CASE_SEQ_REPEAT_EN only)
//   strm              : case_stream_sequencer_if.master, H and alpha channels
//   busy              : high from the cycle after start through DONE
//   done              : one-cycle pulse at end of run
//
// Build option
//   CASE_SEQ_REPEAT_EN : adds the frames port and the frame repeat counter;
//                        without it every run is a single frame.
// -----------------------------------------------------------------------------
module case_stream_sequencer #(
    parameter int J       = 4,
    parameter int I       = 7,
    parameter int A       = 4,
    parameter int DATA_W  = 64,
    parameter int ALPHA_W = 8,
    localparam int AW_RAW = (I > A) ? $clog2(I) : $clog2(A),
    localparam int AW     = (AW_RAW < 1) ? 1 : AW_RAW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_sel,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [J*DATA_W-1:0]   cfg_wdata,
    input  logic                  start,
`ifdef CASE_SEQ_REPEAT_EN
    input  logic [7:0]            frames,
`endif
    case_stream_sequencer_if.master strm,
    output logic                  busy,
    output logic                  done
);
    localparam int HIW = (I > 1) ? $clog2(I) : 1;
    localparam int AIW = (A > 1) ? $clog2(A) : 1;
    localparam logic [AW-1:0] H_LAST = AW'(I - 1);
    localparam logic [AW-1:0] A_LAST = AW'(A - 1);

    typedef enum logic [1:0] {S_IDLE, S_H_SEND, S_ALPHA_SEND, S_DONE} state_t;

    // Case storage: deliberately outside the reset domain so a loaded case
    // survives an abandoned run.
    logic [J*DATA_W-1:0]  h_mem [I];
    logic [2*DATA_W-1:0]  y_mem [I];
    logic [J*ALPHA_W-1:0] a_mem [A];

    state_t               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d, nxt_idx;
`ifdef CASE_SEQ_REPEAT_EN
    logic [7:0]           frm_q, frm_d;
`endif
    logic [J*DATA_W-1:0]  h_row_d, row0_h;
    logic [2*DATA_W-1:0]  y_d, row0_y;
    logic [J*ALPHA_W-1:0] a_col_d;
    logic                 h_vld_d, h_last_d, a_vld_d, a_last_d;
    logic                 idle, h_wr, y_wr, a_wr, h_hs, a_hs;

    assign idle    = (state_q == S_IDLE);
    assign h_wr    = idle && cfg_we && (cfg_sel == 2'd0) && (int'(cfg_addr) < I);
    assign y_wr    = idle && cfg_we && (cfg_sel == 2'd1) && (int'(cfg_addr) < I);
    assign a_wr    = idle && cfg_we && (cfg_sel == 2'd2) && (int'(cfg_addr) < A);
    assign h_hs    = strm.H_row_tvalid && strm.H_row_tready;
    assign a_hs    = strm.alpha_u_col_tvalid && strm.alpha_u_col_tready;
    assign nxt_idx = idx_q + AW'(1);

    // Row 0 is loaded into the output register on the start edge, so a write
    // to row 0 on that same edge is forwarded instead of read from storage.
    assign row0_h = (h_wr && cfg_addr == '0) ? cfg_wdata : h_mem[0];
    assign row0_y = (y_wr && cfg_addr == '0) ? cfg_wdata[2*DATA_W-1:0] : y_mem[0];

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (h_wr) h_mem[cfg_addr[HIW-1:0]] <= cfg_wdata;
        if (y_wr) y_mem[cfg_addr[HIW-1:0]] <= cfg_wdata[2*DATA_W-1:0];
        if (a_wr) a_mem[cfg_addr[AIW-1:0]] <= cfg_wdata[J*ALPHA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                 <= S_IDLE;
            idx_q                   <= '0;
`ifdef CASE_SEQ_REPEAT_EN
            frm_q                   <= '0;
`endif
            strm.H_row              <= '0;
            strm.y                  <= '0;
            strm.H_row_tvalid       <= 1'b0;
            strm.H_row_tlast        <= 1'b0;
            strm.alpha_u_col        <= '0;
            strm.alpha_u_col_tvalid <= 1'b0;
            strm.alpha_u_col_tlast  <= 1'b0;
        end else begin
            state_q                 <= state_d;
            idx_q                   <= idx_d;
`ifdef CASE_SEQ_REPEAT_EN
            frm_q                   <= frm_d;
`endif
            strm.H_row              <= h_row_d;
            strm.y                  <= y_d;
            strm.H_row_tvalid       <= h_vld_d;
            strm.H_row_tlast        <= h_last_d;
            strm.alpha_u_col        <= a_col_d;
            strm.alpha_u_col_tvalid <= a_vld_d;
            strm.alpha_u_col_tlast  <= a_last_d;
        end
    end

    // Next-state logic also computes the next contents of the registered
    // outputs; without a handshake every output holds its current value.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
`ifdef CASE_SEQ_REPEAT_EN
        frm_d    = frm_q;
`endif
        h_row_d  = strm.H_row;
        y_d      = strm.y;
        h_vld_d  = strm.H_row_tvalid;
        h_last_d = strm.H_row_tlast;
        a_col_d  = strm.alpha_u_col;
        a_vld_d  = strm.alpha_u_col_tvalid;
        a_last_d = strm.alpha_u_col_tlast;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_H_SEND;
                    idx_d    = '0;
`ifdef CASE_SEQ_REPEAT_EN
                    frm_d    = (frames == 8'd0) ? 8'd0 : frames - 8'd1;
`endif
                    h_row_d  = row0_h;
                    y_d      = row0_y;
                    h_vld_d  = 1'b1;
                    h_last_d = (I == 1);
                end
            end
            S_H_SEND: begin
                if (h_hs) begin
                    if (idx_q == H_LAST) begin
                        state_d  = S_ALPHA_SEND;
                        idx_d    = '0;
                        h_vld_d  = 1'b0;
                        h_last_d = 1'b0;
                        a_col_d  = a_mem[0];
                        a_vld_d  = 1'b1;
                        a_last_d = (A == 1);
                    end else begin
                        idx_d    = nxt_idx;
                        h_row_d  = h_mem[nxt_idx[HIW-1:0]];
                        y_d      = y_mem[nxt_idx[HIW-1:0]];
                        h_last_d = (nxt_idx == H_LAST);
                    end
                end
            end
            S_ALPHA_SEND: begin
                if (a_hs) begin
                    if (idx_q == A_LAST) begin
                        idx_d    = '0;
                        a_vld_d  = 1'b0;
                        a_last_d = 1'b0;
`ifdef CASE_SEQ_REPEAT_EN
                        if (frm_q != 8'd0) begin
                            frm_d    = frm_q - 8'd1;
                            state_d  = S_H_SEND;
                            h_row_d  = row0_h;
                            y_d      = row0_y;
                            h_vld_d  = 1'b1;
                            h_last_d = (I == 1);
                        end else begin
                            state_d  = S_DONE;
                        end
`else
                        state_d  = S_DONE;
`endif
                    end else begin
                        idx_d    = nxt_idx;
                        a_col_d  = a_mem[nxt_idx[AIW-1:0]];
                        a_last_d = (nxt_idx == A_LAST);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
